// File: rtl/inv_stream_checker.sv
// rtl/inv_stream_checker.sv - self-checking monitor for a registered inverter stream
// Optional: INV_CHK_STOP_ON_ERR_EN freezes the checker in FAIL on the first mismatch.
module inv_stream_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             dut_in,
    input  logic             dut_out,
    output logic [1:0]       state,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] first_err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [3:0]       FILL_LAST = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             st;
    logic [LATENCY-1:0] dl;
    logic [3:0]         fill;
    logic               expected;
    logic               mismatch;

    assign expected = ~dl[LATENCY-1];
    // Case inequality so an X/Z on dut_out is counted as a failure.
    assign mismatch = (dut_out !== expected);
    assign state    = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl <= '0;
        end else begin
            dl <= LATENCY'({dl, dut_in});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            fill          <= '0;
            err_flag      <= 1'b0;
            err_count     <= '0;
            check_count   <= '0;
            first_err_cnt <= '0;
        end else if (clear) begin
            st            <= enable ? PRIME : IDLE;
            fill          <= '0;
            err_flag      <= 1'b0;
            err_count     <= '0;
            check_count   <= '0;
            first_err_cnt <= '0;
        end else begin
            case (st)
                IDLE: begin
                    fill <= '0;
                    if (enable) st <= PRIME;
                end
                PRIME: begin
                    if (!enable) begin
                        st   <= IDLE;
                        fill <= '0;
                    end else begin
                        fill <= fill + 4'd1;
                        if (fill == FILL_LAST) st <= CHECK;
                    end
                end
                CHECK: begin
                    if (!enable) begin
                        st   <= IDLE;
                        fill <= '0;
                    end else begin
                        if (check_count != CNT_MAX) check_count <= check_count + 1'b1;
                        if (mismatch) begin
                            err_flag <= 1'b1;
                            if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
                            if (!err_flag) first_err_cnt <= check_count;
`ifdef INV_CHK_STOP_ON_ERR_EN
                            st <= FAIL;
`endif
                        end
                    end
                end
                default: begin
`ifdef INV_CHK_STOP_ON_ERR_EN
                    st <= FAIL;
`else
                    st   <= IDLE;
                    fill <= '0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_stream_checker.sv
// tb/tb_inv_stream_checker.sv - directed bench for inv_stream_checker
module tb_inv_stream_checker;

`ifdef INV_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, enable, clear, din, stuck;
    logic inv_q;
    logic dout;

    logic [1:0]  st1, st2, st3;
    logic        ef1, ef2, ef3;
    logic [15:0] ec1, cc1, fe1, ec2, cc2, fe2;
    logic [2:0]  ec3, cc3, fe3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) inv_q <= ~din;
    assign dout = stuck ? 1'b0 : inv_q;

    inv_stream_checker #(.LATENCY(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .dut_in(din), .dut_out(dout), .state(st1), .err_flag(ef1),
        .err_count(ec1), .check_count(cc1), .first_err_cnt(fe1));

    inv_stream_checker #(.LATENCY(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .dut_in(din), .dut_out(dout), .state(st2), .err_flag(ef2),
        .err_count(ec2), .check_count(cc2), .first_err_cnt(fe2));

    inv_stream_checker #(.LATENCY(1), .CNT_W(3)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .dut_in(din), .dut_out(dout), .state(st3), .err_flag(ef3),
        .err_count(ec3), .check_count(cc3), .first_err_cnt(fe3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_err, exp_chk, exp_first;
        logic last_din, frozen;

        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; din = 1'b0; stuck = 1'b0;
        tick; tick;
        chk("rst_state", st1, 0);
        chk("rst_flag", ef1, 0);
        chk("rst_err", ec1, 0);
        chk("rst_chk", cc1, 0);
        chk("rst_first", fe1, 0);
        rst_n = 1'b1;

        // Good inverter: 1 IDLE->PRIME edge, 1 PRIME edge, then 9 checks.
        enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            din = (i == 5 || i == 6);
            tick;
        end
        chk("good_state", st1, 2);
        chk("good_flag", ef1, 0);
        chk("good_err", ec1, 0);
        chk("good_chk", cc1, 9);

        // Stuck-at-0 output with toggling stimulus.
        stuck = 1'b1; clear = 1'b1; din = ~din;
        tick;
        chk("clr_state", st1, 1);
        clear = 1'b0; din = ~din;
        tick;
        exp_err = 0; exp_chk = 0; exp_first = 0; frozen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            last_din = din;
            din = ~din;
            tick;
            if (!frozen) begin
                if (last_din == 1'b0) begin
                    if (exp_err == 0) exp_first = exp_chk;
                    exp_err++;
                    if (STOP) frozen = 1'b1;
                end
                exp_chk++;
            end
        end
        chk("stuck_err", ec1, exp_err);
        chk("stuck_chk", cc1, exp_chk);
        chk("stuck_flag", ef1, 1);
        chk("stuck_first", fe1, exp_first);

        // Latency mismatch: LATENCY=2 checker against a 1-clock inverter.
        stuck = 1'b0; clear = 1'b1; din = ~din;
        tick;
        clear = 1'b0;
        for (int k = 0; k < 10; k++) begin
            din = ~din;
            tick;
        end
        chk("lat2_err", ec2, STOP ? 1 : 8);
        chk("lat2_chk", cc2, STOP ? 1 : 8);
        chk("lat1_err", ec1, 0);
        chk("lat1_chk", cc1, 9);

        // First mismatch at pre-increment check_count 2.
        stuck = 1'b1; din = 1'b1; clear = 1'b1;
        tick;
        clear = 1'b0;
        tick;
        tick;
        din = 1'b0;
        tick;
        tick;
        chk("stop_state", st1, STOP ? 3 : 2);
        chk("stop_err", ec1, 1);
        chk("stop_chk", cc1, 3);
        chk("stop_first", fe1, 2);
        tick;
        chk("stop_err2", ec1, STOP ? 1 : 2);
        chk("stop_chk2", cc1, STOP ? 3 : 4);
        enable = 1'b0;
        tick;
        chk("stop_en0_state", st1, STOP ? 3 : 0);
        chk("stop_en0_err", ec1, STOP ? 1 : 2);
        enable = 1'b1; clear = 1'b1;
        tick;
        chk("stop_clr_state", st1, 1);
        chk("stop_clr_err", ec1, 0);
        clear = 1'b0;

        // Three mismatches, then clear concurrent with a mismatch.
        tick;
        tick; tick; tick;
        chk("cm_err", ec1, STOP ? 1 : 3);
        chk("cm_chk", cc1, STOP ? 1 : 3);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("cm_state", st1, 1);
        chk("cm_flag", ef1, 0);
        chk("cm_err0", ec1, 0);
        chk("cm_chk0", cc1, 0);
        chk("cm_first0", fe1, 0);

        // Saturation on the narrow-counter instance.
        tick;
        for (int k = 0; k < 10; k++) tick;
        chk("sat_chk", cc3, STOP ? 1 : 7);
        chk("sat_err", ec3, STOP ? 1 : 7);
        chk("sat_flag", ef3, 1);
        chk("sat_wide_chk", cc1, STOP ? 1 : 10);

        // Enable drop at check_count 5, then resume after re-priming.
        stuck = 1'b0; clear = 1'b1; din = ~din;
        tick;
        clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            din = ~din;
            tick;
        end
        chk("drop_pre_chk", cc1, 5);
        enable = 1'b0; din = ~din;
        tick;
        chk("drop_state", st1, 0);
        chk("drop_chk", cc1, 5);
        din = ~din;
        tick;
        chk("drop_hold", cc1, 5);
        enable = 1'b1; din = ~din;
        tick;
        chk("re_prime", st1, 1);
        din = ~din;
        tick;
        chk("re_check", st1, 2);
        chk("re_chk5", cc1, 5);
        din = ~din;
        tick;
        chk("re_chk6", cc1, 6);
        chk("re_err", ec1, 0);

        // Asynchronous reset mid-CHECK.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", st1, 0);
        chk("arst_chk", cc1, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("arst_prime", st1, 1);
        tick;
        chk("arst_chk0", cc1, 0);
        tick;
        chk("arst_chk1", cc1, 1);
        chk("arst_err", ec1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
